iram_arbiter: RTL and testbench

IRAM_ARBITER -- requirements
Module: iram_arbiter

---
 rtl/iram_arbiter.sv | 137 +++++++++++++
 tb/tb_iram_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iram_arbiter.sv
// rtl/iram_arbiter.sv - multi-core instruction RAM arbiter (IDLE/ISSUE/CAPTURE, 2-cycle read latency)
// Optional macro IARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module iram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [AW*NUM_CORES-1:0] core_addr,
  output logic [NUM_CORES-1:0]    core_gnt,
  output logic [NUM_CORES-1:0]    core_rvalid,
  output logic [DW-1:0]           core_rdata,
  output logic [AW-1:0]           mem_addr,
  input  logic [DW-1:0]           mem_data,
  output logic                    busy
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [NUM_CORES-1:0] win_oh;
  logic [AW-1:0]        win_addr;

  function automatic logic [NUM_CORES-1:0] lowest_oh(input logic [NUM_CORES-1:0] v);
    logic [NUM_CORES-1:0] r;
    r = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (v[j]) begin
        r    = '0;
        r[j] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef IARB_FIXED_PRIO_EN
  always_comb begin
    win_oh = lowest_oh(core_req);
  end
`else
  logic [PW-1:0]        ptr_q, ptr_d, ptr_nxt;
  logic [PW-1:0]        win_idx;
  logic [NUM_CORES-1:0] hi_mask;
  logic [NUM_CORES-1:0] req_hi;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      hi_mask[j] = (PW'(j) >= ptr_q);
    end
    req_hi  = core_req & hi_mask;
    win_oh  = (|req_hi) ? lowest_oh(req_hi) : lowest_oh(core_req);
    win_idx = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (win_oh[j]) win_idx = PW'(j);
    end
    ptr_nxt = (win_idx == PW'(NUM_CORES - 1)) ? '0 : win_idx + PW'(1);
  end
`endif

  always_comb begin
    win_addr = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (win_oh[j]) win_addr = core_addr[j*AW +: AW];
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
`ifndef IARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|core_req) begin
          gnt_d   = win_oh;
          addr_d  = win_addr;
          state_d = ISSUE;
`ifndef IARB_FIXED_PRIO_EN
          ptr_d   = ptr_nxt;
`endif
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        // RAM sampled mem_addr at the ISSUE edge, so mem_data is valid now.
        rdata_d  = mem_data;
        rvalid_d = gnt_q;
        gnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
`ifndef IARB_FIXED_PRIO_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
`ifndef IARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign core_gnt    = gnt_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign mem_addr    = addr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_iram_arbiter.sv
// tb/tb_iram_arbiter.sv - directed self-checking bench for iram_arbiter
module tb_iram_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  core_req;
  logic [63:0] core_addr;
  logic [3:0]  core_gnt;
  logic [3:0]  core_rvalid;
  logic [15:0] core_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;

  logic [15:0] ram [0:15];
  int checks;
  int failures;

  iram_arbiter #(.NUM_CORES(4), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_addr(core_addr),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= ram[mem_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int core, input logic [15:0] a);
    core_addr[core*16 +: 16] = a;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [15:0] rdata_exp);
    chk({tag, "_gnt"}, {28'd0, core_gnt}, 32'h0);
    chk({tag, "_rvalid"}, {28'd0, core_rvalid}, 32'h0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'h0);
    chk({tag, "_rdata"}, {16'd0, core_rdata}, {16'd0, rdata_exp});
  endtask

  logic [3:0] exp_oh;
  int exp_core [0:4];
  int alt_core [0:2];

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0100 + 16'(i);
    ram[1] = 16'd25;
    ram[5] = 16'h0055;
    ram[6] = 16'h0026;
    ram[7] = 16'h0707;
    ram[9] = 16'h0909;
    rst = 1'b1;
    core_req = 4'b0000;
    core_addr = '0;
    mem_data = '0;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 16'h0000);
    chk("reset_mem_addr", {16'd0, mem_addr}, 32'h0);
    rst = 1'b0;

    // Single request: core 1 at addr 1
    @(negedge clk);
    core_req = 4'b0010;
    set_addr(1, 16'd1);
    @(negedge clk);
    chk("single_gnt", {28'd0, core_gnt}, 32'b0010);
    chk("single_mem_addr", {16'd0, mem_addr}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_rvalid_early", {28'd0, core_rvalid}, 32'h0);
    core_req = 4'b0000;
    @(negedge clk);
    chk("single_gnt_issue", {28'd0, core_gnt}, 32'b0010);
    chk("single_rvalid_issue", {28'd0, core_rvalid}, 32'h0);
    @(negedge clk);
    chk("single_rvalid", {28'd0, core_rvalid}, 32'b0010);
    chk("single_rdata", {16'd0, core_rdata}, 32'd25);
    chk("single_gnt_clear", {28'd0, core_gnt}, 32'h0);
    chk("single_busy_clear", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("single_rvalid_pulse", {28'd0, core_rvalid}, 32'h0);
    chk("single_rdata_hold", {16'd0, core_rdata}, 32'd25);

    // Mid-access change: core 3 addr 7, then drops req and moves addr to 9
    core_req = 4'b1000;
    set_addr(3, 16'd7);
    @(negedge clk);
    chk("mid_gnt", {28'd0, core_gnt}, 32'b1000);
    chk("mid_mem_addr", {16'd0, mem_addr}, 32'd7);
    core_req = 4'b0000;
    set_addr(3, 16'd9);
    @(negedge clk);
    chk("mid_mem_addr_hold", {16'd0, mem_addr}, 32'd7);
    chk("mid_gnt_hold", {28'd0, core_gnt}, 32'b1000);
    @(negedge clk);
    chk("mid_rvalid", {28'd0, core_rvalid}, 32'b1000);
    chk("mid_rdata", {16'd0, core_rdata}, 32'h0707);
    @(negedge clk);
    chk("mid_no_regrant", {28'd0, core_gnt}, 32'h0);

    // Reset during CAPTURE: core 2 addr 5
    core_req = 4'b0100;
    set_addr(2, 16'd5);
    @(negedge clk);
    chk("rstcap_gnt", {28'd0, core_gnt}, 32'b0100);
    core_req = 4'b0000;
    @(negedge clk);
    chk("rstcap_busy_capture", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("rstcap_async", 16'h0000);
    chk("rstcap_mem_addr", {16'd0, mem_addr}, 32'h0);
    @(negedge clk);
    chk_idle_outputs("rstcap_held", 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rstcap_after", 16'h0000);

    // All four cores continuously requesting; pointer restarted at 0
`ifdef IARB_FIXED_PRIO_EN
    exp_core = '{0, 0, 0, 0, 0};
`else
    exp_core = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) set_addr(i, 16'(i));
    core_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_oh = 4'b0001 << exp_core[n];
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", n), {28'd0, core_gnt}, {28'd0, exp_oh});
      chk($sformatf("rr%0d_mem_addr", n), {16'd0, mem_addr}, exp_core[n]);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_rvalid", n), {28'd0, core_rvalid}, {28'd0, exp_oh});
      chk($sformatf("rr%0d_rdata", n), {16'd0, core_rdata}, {16'd0, ram[exp_core[n]]});
      if (n == 4) core_req = 4'b0000;
    end

    // Access returning 0x0026 then 10 idle cycles
    core_req = 4'b0001;
    set_addr(0, 16'd6);
    @(negedge clk);
    chk("hold_gnt", {28'd0, core_gnt}, 32'b0001);
    core_req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("hold_rdata_load", {16'd0, core_rdata}, 32'h0026);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("hold%0d", c), 16'h0026);
    end

    // Cores 0 and 2 continuously requesting
`ifdef IARB_FIXED_PRIO_EN
    alt_core = '{0, 0, 0};
`else
    alt_core = '{2, 0, 2};
`endif
    set_addr(0, 16'd4);
    set_addr(2, 16'd8);
    core_req = 4'b0101;
    for (int n = 0; n < 3; n++) begin
      exp_oh = 4'b0001 << alt_core[n];
      @(negedge clk);
      chk($sformatf("alt%0d_gnt", n), {28'd0, core_gnt}, {28'd0, exp_oh});
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("alt%0d_rvalid", n), {28'd0, core_rvalid}, {28'd0, exp_oh});
      chk($sformatf("alt%0d_rdata", n), {16'd0, core_rdata},
          {16'd0, ram[(alt_core[n] == 0) ? 4 : 8]});
    end
    core_req = 4'b0000;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
